data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 1024 x 32-bit data memory. Two requesters share the memory's single address/data/write-enable port: port 0 is the core load/store unit and port 1 is the debug/loader port. The block grants one access per cycle with round-robin fairness and returns registered read data. An optional post-reset clear engine zeroes the whole memory before any grant is issued. It sits between the requesters and the data memory; the memory stays purely a storage array.

---
 rtl/data_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory.
// Optional post-reset zero-clear engine is enabled by defining DATA_MEM_CLEAR_EN.
module data_mem_arbiter #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,

    output logic          busy
);

    logic          prio_q, prio_d;
    logic          m0_rvalid_q, m0_rvalid_d;
    logic          m1_rvalid_q, m1_rvalid_d;
    logic [DW-1:0] m0_rdata_q, m0_rdata_d;
    logic [DW-1:0] m1_rdata_q, m1_rdata_d;
    logic          clearing;
    logic [AW-1:0] clr_addr;

`ifdef DATA_MEM_CLEAR_EN
    typedef enum logic {
        ST_CLEAR,
        ST_ARB
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    // The counter stops at the last address; the state change ends the sweep.
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            if (clr_addr_q == '1) begin
                state_d = ST_ARB;
            end else begin
                clr_addr_d = clr_addr_q + AW'(1);
            end
        end
    end

    assign clearing = (state_q == ST_CLEAR);
    assign clr_addr = clr_addr_q;
`else
    assign clearing = 1'b0;
    assign clr_addr = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
        end else begin
            prio_q      <= prio_d;
            m0_rvalid_q <= m0_rvalid_d;
            m1_rvalid_q <= m1_rvalid_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
        end
    end

    // With no grant the memory port still follows the favoured requester.
    always_comb begin
        logic arb_ok;
        logic sel1;

        arb_ok = !rst && !clearing;
        m0_gnt = arb_ok && m0_req && (!m1_req || !prio_q);
        m1_gnt = arb_ok && m1_req && (!m0_req || prio_q);
        sel1   = m1_gnt || (!m0_gnt && prio_q);

        mem_addr  = sel1 ? m1_addr  : m0_addr;
        mem_wdata = sel1 ? m1_wdata : m0_wdata;
        mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
        busy      = clearing;

        if (clearing) begin
            mem_addr  = clr_addr;
            mem_wdata = '0;
            mem_we    = !rst;
        end

        prio_d = prio_q;
        if (m0_gnt) begin
            prio_d = 1'b1;
        end else if (m1_gnt) begin
            prio_d = 1'b0;
        end

        m0_rvalid_d = m0_gnt && !m0_we;
        m1_rvalid_d = m1_gnt && !m1_we;
        m0_rdata_d  = m0_rvalid_d ? mem_rdata : m0_rdata_q;
        m1_rdata_d  = m1_rvalid_d ? mem_rdata : m1_rdata_q;
    end

    assign m0_rvalid = m0_rvalid_q;
    assign m1_rvalid = m1_rvalid_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed testbench for data_mem_arbiter with a behavioural 1024x32 memory.
// Clear-engine scenarios are exercised when DATA_MEM_CLEAR_EN is defined.
module tb_data_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we;
    logic          busy;

    logic [DW-1:0] memArray [0:(1<<AW)-1];

    int errors = 0;
    int checks = 0;

`ifdef DATA_MEM_CLEAR_EN
    localparam logic BUSY_IN_RESET = 1'b1;
`else
    localparam logic BUSY_IN_RESET = 1'b0;
`endif

    always #5 clk = ~clk;

    data_mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural memory: combinational read, write at the end of the cycle.
    assign mem_rdata = memArray[mem_addr];

    always @(posedge clk) begin
        if (mem_we) memArray[mem_addr] <= mem_wdata;
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) memArray[i] = 32'hA5A50000 | i;
    end

    function automatic logic [DW-1:0] initVal(input logic [AW-1:0] a);
`ifdef DATA_MEM_CLEAR_EN
        return '0;
`else
        return 32'hA5A50000 | {22'd0, a};
`endif
    endfunction

    task automatic idleInputs();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

`ifdef DATA_MEM_CLEAR_EN
    // Expects to be called in the first cycle after rst falls.
    task automatic checkClear(input int n, input bit full);
        for (int i = 0; i < n; i++) begin
            if (i > 0) nextCycle();
            checks++;
            if (busy !== 1'b1 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0 ||
                mem_we !== 1'b1 || mem_addr !== AW'(i) || mem_wdata !== '0) begin
                errors++;
                $display("[TB] FAIL clear_cycle %0d: busy=%b gnt=%b%b we=%b addr=%0h wdata=%0h want busy=1 gnt=00 we=1 addr=%0h wdata=0",
                         i, busy, m0_gnt, m1_gnt, mem_we, mem_addr, mem_wdata, i);
            end
        end
        if (full) begin
            nextCycle();
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL clear_done_busy: got %b want 0", busy);
            end
        end
    endtask
`endif

    task automatic doReset();
        rst = 1;
        nextCycle();
        nextCycle();
        rst = 0;
        #1;
`ifdef DATA_MEM_CLEAR_EN
        checkClear(1 << AW, 1'b1);
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_busy_after: got %b want 0", busy);
        end
`endif
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        idleInputs();
        m0_req = 1; m0_addr = 10'h3FF;
        m1_req = 1; m1_addr = 10'h3FE;
        rst = 1;
        nextCycle();
        nextCycle();
        checks++;
        if (m0_gnt !== 0 || m1_gnt !== 0 || mem_we !== 0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: gnt=%b%b we=%b want gnt=00 we=0", m0_gnt, m1_gnt, mem_we);
        end
        checks++;
        if (busy !== BUSY_IN_RESET) begin
            errors++;
            $display("[TB] FAIL reset_busy: got %b want %b", busy, BUSY_IN_RESET);
        end
        checks++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0 || m0_rdata !== '0 || m1_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_read_regs: rv=%b%b rd0=%h rd1=%h want 0", m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
        end
        rst = 0;
        #1;
`ifdef DATA_MEM_CLEAR_EN
        checkClear(1 << AW, 1'b1);
`else
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL first_cycle_busy: got %b want 0", busy);
        end
`endif
        checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0 || mem_addr !== 10'h3FF || mem_we !== 0) begin
            errors++;
            $display("[TB] FAIL first_grant: gnt=%b%b addr=%h we=%b want gnt=10 addr=3ff we=0", m0_gnt, m1_gnt, mem_addr, mem_we);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 1 || m0_rdata !== initVal(10'h3FF)) begin
            errors++;
            $display("[TB] FAIL read_3ff: rv=%b rd=%h want rv=1 rd=%h", m0_rvalid, m0_rdata, initVal(10'h3FF));
        end
        m0_req = 0;
        #1;
        checks++;
        if (m1_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL second_grant_m1: got %b want 1", m1_gnt);
        end
        nextCycle();
        checks++;
        if (m1_rvalid !== 1 || m1_rdata !== initVal(10'h3FE) || m0_rvalid !== 0) begin
            errors++;
            $display("[TB] FAIL read_3fe: rv1=%b rd1=%h rv0=%b want 1 %h 0", m1_rvalid, m1_rdata, m0_rvalid, initVal(10'h3FE));
        end
        idleInputs();
    endtask

    task automatic test_tie_fairness();
        bit g0;
        $display("[TB] test_tie_fairness");
        idleInputs();
        doReset();
        nextCycle();
        m0_req = 1; m0_addr = 10'd10;
        m1_req = 1; m1_addr = 10'd20;
        for (int k = 0; k < 4; k++) begin
            g0 = (k % 2 == 0);
            #1;
            checks++;
            if (m0_gnt !== g0 || m1_gnt !== !g0) begin
                errors++;
                $display("[TB] FAIL tie_grant %0d: gnt=%b%b want %b%b", k, m0_gnt, m1_gnt, g0, !g0);
            end
            nextCycle();
            checks++;
            if (m0_rvalid !== g0 || m1_rvalid !== !g0 ||
                (g0 && m0_rdata !== initVal(10'd10)) || (!g0 && m1_rdata !== initVal(10'd20))) begin
                errors++;
                $display("[TB] FAIL tie_rvalid %0d: rv=%b%b rd0=%h rd1=%h", k, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata);
            end
        end
        idleInputs();
        nextCycle();
        checks++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
            errors++;
            $display("[TB] FAIL tie_rvalid_end: rv=%b%b want 00", m0_rvalid, m1_rvalid);
        end
    endtask

    task automatic test_single_port();
        $display("[TB] test_single_port");
        idleInputs();
        m0_req = 1; m0_we = 1; m0_addr = 10'd5; m0_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if (m0_gnt !== 1 || mem_we !== 1 || mem_addr !== 10'd5 || mem_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL sp_write_grant: gnt=%b we=%b addr=%h wd=%h", m0_gnt, mem_we, mem_addr, mem_wdata);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 0) begin
            errors++;
            $display("[TB] FAIL sp_write_no_rvalid: got %b want 0", m0_rvalid);
        end
        m0_we = 0;
        #1;
        checks++;
        if (m0_gnt !== 1 || mem_we !== 0) begin
            errors++;
            $display("[TB] FAIL sp_read_grant: gnt=%b we=%b want 1 0", m0_gnt, mem_we);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL sp_read_data: rv=%b rd=%h want 1 deadbeef", m0_rvalid, m0_rdata);
        end
        m0_req = 0;
        nextCycle();
        checks++;
        if (m0_rvalid !== 0 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL sp_rdata_hold: rv=%b rd=%h want 0 deadbeef", m0_rvalid, m0_rdata);
        end
    endtask

    task automatic test_cross_port();
        $display("[TB] test_cross_port");
        idleInputs();
        m1_req = 1; m1_we = 1; m1_addr = 10'h200; m1_wdata = 32'h12345678;
        #1;
        checks++;
        if (m1_gnt !== 1 || mem_we !== 1 || mem_addr !== 10'h200) begin
            errors++;
            $display("[TB] FAIL cp_write_grant: gnt=%b we=%b addr=%h", m1_gnt, mem_we, mem_addr);
        end
        nextCycle();
        m1_req = 0; m1_we = 0;
        m0_req = 1; m0_we = 0; m0_addr = 10'h200;
        #1;
        checks++;
        if (m0_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL cp_read_grant: got %b want 1", m0_gnt);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL cp_read_data: rv=%b rd=%h want 1 12345678", m0_rvalid, m0_rdata);
        end
        idleInputs();
    endtask

    task automatic test_withdrawn();
        $display("[TB] test_withdrawn");
        idleInputs();
        nextCycle();
        m1_req = 1; m1_addr = 10'h200;
        #1;
        checks++;
        if (m1_gnt !== 1 || m0_gnt !== 0) begin
            errors++;
            $display("[TB] FAIL wd_m1_alone: gnt=%b%b want 01", m0_gnt, m1_gnt);
        end
        nextCycle();
        checks++;
        if (m1_rvalid !== 1 || m1_rdata !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL wd_m1_read: rv=%b rd=%h want 1 12345678", m1_rvalid, m1_rdata);
        end
        m0_req = 1; m0_addr = 10'd5;
        m1_req = 1; m1_addr = 10'd9;
        #1;
        checks++;
        if (m0_gnt !== 1 || m1_gnt !== 0) begin
            errors++;
            $display("[TB] FAIL wd_tie: gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 1 || m0_rdata !== 32'hDEADBEEF || m1_rvalid !== 0) begin
            errors++;
            $display("[TB] FAIL wd_tie_read: rv=%b%b rd0=%h want 10 deadbeef", m0_rvalid, m1_rvalid, m0_rdata);
        end
        m0_req = 0;
        m1_req = 0;
        #1;
        checks++;
        if (m0_gnt !== 0 || m1_gnt !== 0 || mem_we !== 0 || mem_addr !== 10'd9) begin
            errors++;
            $display("[TB] FAIL wd_idle: gnt=%b%b we=%b addr=%h want 00 0 009", m0_gnt, m1_gnt, mem_we, mem_addr);
        end
        nextCycle();
        checks++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0) begin
            errors++;
            $display("[TB] FAIL wd_no_rvalid: rv=%b%b want 00", m0_rvalid, m1_rvalid);
        end
        m0_req = 1;
        m1_req = 1;
        #1;
        checks++;
        if (m0_gnt !== 0 || m1_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL wd_prio_kept: gnt=%b%b want 01", m0_gnt, m1_gnt);
        end
        nextCycle();
        checks++;
        if (m1_rvalid !== 1 || m1_rdata !== initVal(10'd9)) begin
            errors++;
            $display("[TB] FAIL wd_m1_late_read: rv=%b rd=%h want 1 %h", m1_rvalid, m1_rdata, initVal(10'd9));
        end
        idleInputs();
    endtask

    task automatic test_reset_after_read();
        $display("[TB] test_reset_after_read");
        idleInputs();
        nextCycle();
        m0_req = 1; m0_addr = 10'd5;
        #1;
        checks++;
        if (m0_gnt !== 1) begin
            errors++;
            $display("[TB] FAIL rar_grant: got %b want 1", m0_gnt);
        end
        nextCycle();
        m0_req = 0;
        rst = 1;
        #1;
        checks++;
        if (m0_rvalid !== 0 || m0_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL rar_rvalid_lost: rv=%b rd=%h want 0 0", m0_rvalid, m0_rdata);
        end
        doReset();
    endtask

`ifdef DATA_MEM_CLEAR_EN
    task automatic test_mid_clear_reset();
        $display("[TB] test_mid_clear_reset");
        idleInputs();
        rst = 1;
        nextCycle();
        rst = 0;
        #1;
        checkClear(300, 1'b0);
        nextCycle();
        checks++;
        if (mem_addr !== 10'd300) begin
            errors++;
            $display("[TB] FAIL mc_addr_300: got %0d want 300", mem_addr);
        end
        rst = 1;
        #1;
        checks++;
        if (mem_we !== 0 || busy !== 1) begin
            errors++;
            $display("[TB] FAIL mc_in_reset: we=%b busy=%b want 0 1", mem_we, busy);
        end
        nextCycle();
        rst = 0;
        #1;
        checkClear(1 << AW, 1'b1);
    endtask
`endif

    initial begin
        idleInputs();
        rst = 1;
        test_reset();
        test_tie_fairness();
        test_single_port();
        test_cross_port();
        test_withdrawn();
        test_reset_after_read();
`ifdef DATA_MEM_CLEAR_EN
        test_mid_clear_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
